mpmc11_burst_sequencer: RTL and testbench
=========================================

Name: mpmc11_burst_sequencer

Overview:
- Sequences one multi-beat read or write transaction onto the MIG user interface (app_en/app_cmd/app_addr, write-data FIFO, read-data return) on behalf of the mpmc11 channel arbiter.
- Accepts a latched request, issues one command per beat with address stepping, and honours app_rdy/app_wdf_rdy backpressure.
- Counts returned read beats and signals completion.
- Sits between the channel arbiter/request mux and the MIG core.

Parameters:
- AW, 29, app_addr width.
- ADDR_INC, 8, app_addr increment per beat (one BL8 command).
- TIMEOUT, 1023, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock (MIG ui_clk domain).
- rst  in  1  synchronous reset, active-high.
- req  in  1  transaction request; hold until ack.
- req_we  in  1  1 = write, 0 = read.
- req_adr  in  AW  start app address.
- req_len  in  8  beats minus one (0..255).
- ack  out  1  one-cycle pulse when a request is latched.
- app_rdy  in  1  MIG command ready.
- app_wdf_rdy  in  1  MIG write FIFO ready.
- app_rd_data_valid  in  1  MIG read beat valid.
- app_en  out  1  command enable.
- app_cmd  out  3  3'b000 = write, 3'b001 = read.
- app_addr  out  AW  current beat address.
- app_wdf_wren  out  1  write-data enable.
- app_wdf_end  out  1  last word of write-data transfer (= app_wdf_wren).
- wbeat  out  1  pulse: write beat consumed; requester advances its data.
- rbeat  out  1  pulse: read beat accepted (= qualified app_rd_data_valid).
- burst_cnt  out  8  beats completed in the current phase.
- state  out  3  IDLE=0, WRITE=1, READ_CMD=2, READ_WAIT=3, DONE=4.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  completion was a timeout abort.

Behaviour:
- Reset: state=IDLE. ack, done, err, burst_cnt, cmd_cnt, app_addr, latched fields = 0. All combinational enables are 0 in IDLE.
- IDLE: if req=1, latch req_we/req_adr/req_len, app_addr<=req_adr, clear counters, ack<=1 (registered, one cycle). Next state is WRITE if req_we=1, otherwise READ_CMD.
- WRITE:
  - app_en = app_wdf_wren = wbeat = app_rdy & app_wdf_rdy (combinational). app_cmd=000.
  - On accept: app_addr += ADDR_INC (wraps modulo 2^AW), burst_cnt++.
  - Accept with burst_cnt==len -> DONE.
  - Either ready low -> hold everything; no partial transfer.
- READ_CMD:
  - app_en = app_rdy. app_cmd=001.
  - On accept: app_addr += ADDR_INC, cmd_cnt++.
  - Accept with cmd_cnt==len -> READ_WAIT.
- Read-beat counting in READ_CMD and READ_WAIT: rbeat = app_rd_data_valid; burst_cnt++ per beat. Data may return while commands are still issuing.
- READ_WAIT: rbeat with burst_cnt==len -> DONE. If the final beat arrives in the same cycle as the final command accept, go directly to DONE.
- DONE: done=1 for one cycle -> IDLE. Outputs app_en=0. burst_cnt holds its final value until the next ack.
- app_rd_data_valid is ignored in IDLE, WRITE and DONE: rbeat=0, no count. This covers stray beats after a reset.
- req high in IDLE on the cycle after DONE -> new request accepted, so back-to-back transactions have a 1-cycle IDLE gap.
- req_len=0 is a single beat.
- Reset mid-transaction: return to IDLE next cycle, all outputs deassert, in-flight MIG data discarded.
- No combinational path from app_en to app_rdy is assumed.

Optional Feature:
- MPMC11_SEQ_TIMEOUT_EN defined:
  - A 10-bit idle counter clears on any accept or rbeat and on entry to a non-IDLE state, and increments otherwise while busy.
  - Reaching TIMEOUT -> DONE with err=1 for the done cycle.
  - err clears on the next ack.
- Undefined: no counter, err tied 0.

Test Plan:
- Write, adr=0x100, len=3, both readies high -> app_en on 4 consecutive cycles with app_addr 0x100, 0x108, 0x110, 0x118; done pulses the cycle after the 4th accept; ack exactly once.
- Write backpressure, len=1, app_wdf_rdy low on the first WRITE cycle -> no app_en/wren that cycle, app_addr holds 0x100; exactly 2 wbeats total; done after the 2nd.
- Read, len=7, app_rdy high, data returns 12 cycles after each command -> 8 commands at consecutive addresses, state READ_WAIT after the 8th; done one cycle after the 8th rbeat; burst_cnt=8'd7 at done.
- Read, len=0, final command and app_rd_data_valid in the same cycle -> state goes directly to DONE; done pulses once.
- Reset asserted mid-write after 2 beats -> next cycle state=0, app_en=0, busy=0. A subsequent stray app_rd_data_valid gives rbeat=0.
- With MPMC11_SEQ_TIMEOUT_EN, read with app_rdy stuck low -> done with err=1 exactly TIMEOUT cycles after entering READ_CMD. Without the macro, the sequencer stays in READ_CMD and err stays 0.

Source files
------------

// File: rtl/mpmc11_burst_sequencer.sv
// Drives one multi-beat MIG transaction (one BL8 command per beat); ack/state registered, enables combinational.
// Stalls on app_rdy/app_wdf_rdy without partial transfers; read completion tracks returned beats.
// MPMC11_SEQ_TIMEOUT_EN adds a watchdog that aborts a stalled phase with err set.
module mpmc11_burst_sequencer #(
    parameter int AW       = 29,
    parameter int ADDR_INC = 8,
    parameter int TIMEOUT  = 1023
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          req_we,
    input  logic [AW-1:0] req_adr,
    input  logic [7:0]    req_len,
    output logic          ack,
    input  logic          app_rdy,
    input  logic          app_wdf_rdy,
    input  logic          app_rd_data_valid,
    output logic          app_en,
    output logic [2:0]    app_cmd,
    output logic [AW-1:0] app_addr,
    output logic          app_wdf_wren,
    output logic          app_wdf_end,
    output logic          wbeat,
    output logic          rbeat,
    output logic [7:0]    burst_cnt,
    output logic [2:0]    state,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WRITE     = 3'd1,
        S_READ_CMD  = 3'd2,
        S_READ_WAIT = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t     state_q, state_nxt;
    logic       we_q;
    logic [7:0] len_q;
    logic [7:0] cmd_cnt;
    logic       w_acc, c_acc, rb;
    logic       last_w, last_c, last_r;
    logic       to_abort;

    assign state = state_q;
    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_DONE);

    assign w_acc  = (state_q == S_WRITE) & app_rdy & app_wdf_rdy;
    assign c_acc  = (state_q == S_READ_CMD) & app_rdy;
    assign rb     = ((state_q == S_READ_CMD) | (state_q == S_READ_WAIT)) & app_rd_data_valid;
    assign last_w = w_acc & (burst_cnt == len_q);
    assign last_c = c_acc & (cmd_cnt == len_q);
    assign last_r = rb & (burst_cnt == len_q);

    assign app_en       = w_acc | c_acc;
    assign app_cmd      = ((state_q == S_WRITE) | (state_q == S_READ_CMD)) ? {2'b00, ~we_q} : 3'b000;
    assign app_wdf_wren = w_acc;
    assign app_wdf_end  = w_acc;
    assign wbeat        = w_acc;
    assign rbeat        = rb;

`ifdef MPMC11_SEQ_TIMEOUT_EN
    logic [9:0] idle_cnt;
    logic       err_q;

    // Abort only when the phase would otherwise sit still for another cycle.
    assign to_abort = ((state_q == S_WRITE) | (state_q == S_READ_CMD) | (state_q == S_READ_WAIT))
                      & ~(w_acc | c_acc | rb) & (idle_cnt == 10'(TIMEOUT - 1));
    assign err = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (((state_nxt != state_q) && (state_nxt != S_IDLE)) || w_acc || c_acc || rb)
                idle_cnt <= '0;
            else if (busy)
                idle_cnt <= idle_cnt + 10'd1;
            if (to_abort)
                err_q <= 1'b1;
            else if (state_q == S_IDLE && req)
                err_q <= 1'b0;
        end
    end
`else
    assign to_abort = 1'b0;
    assign err      = 1'b0;
`endif

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:      if (req) state_nxt = req_we ? S_WRITE : S_READ_CMD;
            S_WRITE:     if (last_w) state_nxt = S_DONE;
            S_READ_CMD:  if (last_c) state_nxt = last_r ? S_DONE : S_READ_WAIT;
            S_READ_WAIT: if (last_r) state_nxt = S_DONE;
            S_DONE:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
        if (to_abort)
            state_nxt = S_DONE;
    end

    // The final beat of a phase leaves burst_cnt at len rather than wrapping past it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ack       <= 1'b0;
            we_q      <= 1'b0;
            len_q     <= '0;
            app_addr  <= '0;
            burst_cnt <= '0;
            cmd_cnt   <= '0;
        end else begin
            state_q <= state_nxt;
            ack     <= 1'b0;
            if (state_q == S_IDLE) begin
                if (req) begin
                    we_q      <= req_we;
                    len_q     <= req_len;
                    app_addr  <= req_adr;
                    burst_cnt <= '0;
                    cmd_cnt   <= '0;
                    ack       <= 1'b1;
                end
            end else begin
                if (w_acc || c_acc)
                    app_addr <= app_addr + AW'(ADDR_INC);
                if ((w_acc && !last_w) || (rb && !last_r))
                    burst_cnt <= burst_cnt + 8'd1;
                if (c_acc && !last_c)
                    cmd_cnt <= cmd_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mpmc11_burst_sequencer.sv
// Directed plus randomized transactions against an address-list / return-queue reference model.
module tb_mpmc11_burst_sequencer;
    localparam int AW = 29;
    localparam int INC = 8;
    localparam int TO = 1023;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_adr = '0;
    logic [7:0]    req_len = '0;
    logic          app_rdy = 1'b0;
    logic          app_wdf_rdy = 1'b0;
    logic          app_rd_data_valid = 1'b0;
    logic          ack, app_en, app_wdf_wren, app_wdf_end, wbeat, rbeat, busy, done, err;
    logic [2:0]    app_cmd, state;
    logic [AW-1:0] app_addr;
    logic [7:0]    burst_cnt;

    int checks = 0;
    int errors = 0;

    mpmc11_burst_sequencer #(.AW(AW), .ADDR_INC(INC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_adr(req_adr), .req_len(req_len),
        .ack(ack), .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .app_rd_data_valid(app_rd_data_valid),
        .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_wdf_wren(app_wdf_wren),
        .app_wdf_end(app_wdf_end), .wbeat(wbeat), .rbeat(rbeat), .burst_cnt(burst_cnt),
        .state(state), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] base, input int k);
        return base + AW'(k * INC);
    endfunction

    // Request presented in an IDLE cycle; the next cycle must show ack and the phase state.
    task automatic start(input logic we, input logic [AW-1:0] adr, input logic [7:0] len);
        @(negedge clk);
        req = 1'b1; req_we = we; req_adr = adr; req_len = len;
        app_rdy = 1'b0; app_wdf_rdy = 1'b0; app_rd_data_valid = 1'b0;
        #1;
        chk("idle_state", state, 0);
        chk("idle_ack", ack, 0);
        chk("idle_en", app_en, 0);
        @(negedge clk);
        chk("ack_pulse", ack, 1);
        chk("phase_state", state, we ? 1 : 2);
        req = 1'b0;
    endtask

    // mode 0: readies high; 1: random readies; 2: write FIFO not ready on the first cycle
    task automatic run_write(input logic [AW-1:0] adr, input logic [7:0] len, input int mode);
        int  k = 0;
        bit  fin = 0;
        logic r, w;
        start(1'b1, adr, len);
        for (int c = 0; c < 3000 && !fin; c++) begin
            if (c > 0) @(negedge clk);
            if (k > int'(len)) begin
                app_rdy = 1'b0; app_wdf_rdy = 1'b0;
                #1;
                chk("wr_done", done, 1);
                chk("wr_done_state", state, 4);
                chk("wr_done_cnt", burst_cnt, len);
                chk("wr_done_en", app_en, 0);
                chk("wr_err", err, 0);
                fin = 1;
            end else begin
                r = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
                w = (mode == 1) ? ($urandom_range(0, 3) != 0) : !(mode == 2 && c == 0);
                app_rdy = r; app_wdf_rdy = w;
                #1;
                chk("wr_state", state, 1);
                chk("wr_ack", ack, (c == 0));
                chk("wr_en", app_en, r & w);
                chk("wr_wren", app_wdf_wren, r & w);
                chk("wr_end", app_wdf_end, r & w);
                chk("wr_wbeat", wbeat, r & w);
                chk("wr_rbeat", rbeat, 0);
                chk("wr_cmd", app_cmd, 0);
                chk("wr_addr", app_addr, beat_addr(adr, k));
                chk("wr_cnt", burst_cnt, k);
                chk("wr_nodone", done, 0);
                if (r & w) k++;
            end
        end
        if (!fin) chk("wr_budget", 0, 1);
    endtask

    task automatic run_read(input logic [AW-1:0] adr, input logic [7:0] len, input int lat, input int mode);
        int  nc = 0;
        int  nb = 0;
        int  ret[$];
        bit  fin = 0;
        logic r, acc, v;
        start(1'b0, adr, len);
        for (int c = 0; c < 4000 && !fin; c++) begin
            if (c > 0) @(negedge clk);
            if (nb > int'(len)) begin
                app_rdy = 1'b0; app_rd_data_valid = 1'b0;
                #1;
                chk("rd_done", done, 1);
                chk("rd_done_state", state, 4);
                chk("rd_done_cnt", burst_cnt, len);
                chk("rd_done_en", app_en, 0);
                fin = 1;
            end else begin
                r = (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (nc > int'(len)) r = 1'($urandom_range(0, 1));
                acc = r && (nc <= int'(len));
                if (acc) ret.push_back(c + lat);
                v = (ret.size() > 0) && (ret[0] == c);
                if (v) void'(ret.pop_front());
                app_rdy = r; app_rd_data_valid = v;
                #1;
                chk("rd_state", state, (nc <= int'(len)) ? 2 : 3);
                chk("rd_ack", ack, (c == 0));
                chk("rd_en", app_en, acc);
                chk("rd_wbeat", wbeat, 0);
                chk("rd_wren", app_wdf_wren, 0);
                chk("rd_rbeat", rbeat, v);
                chk("rd_cnt", burst_cnt, nb);
                chk("rd_nodone", done, 0);
                if (nc <= int'(len)) begin
                    chk("rd_cmd", app_cmd, 1);
                    chk("rd_addr", app_addr, beat_addr(adr, nc));
                end
                if (acc) nc++;
                if (v) nb++;
            end
        end
        if (!fin) chk("rd_budget", 0, 1);
    endtask

    initial begin
        app_rd_data_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_state", state, 0);
        chk("rst_ack", ack, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_cnt", burst_cnt, 0);
        chk("rst_addr", app_addr, 0);
        chk("rst_en", app_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rbeat", rbeat, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_stray_rbeat", rbeat, 0);

        run_write(29'h100, 8'd3, 0);
        run_write(29'h100, 8'd1, 2);
        run_read(29'h100, 8'd7, 12, 0);
        run_read(29'h200, 8'd0, 0, 0);
        run_write(29'h1FFF_FFF0, 8'd4, 1);
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 1)
                run_write(AW'($urandom), 8'($urandom_range(0, 20)), 1);
            else
                run_read(AW'($urandom), 8'($urandom_range(0, 20)), $urandom_range(0, 15), 1);
        end

        // Reset in the middle of a write after two accepted beats.
        start(1'b1, 29'h300, 8'd5);
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        #1 chk("mid_en0", app_en, 1);
        @(negedge clk);
        #1 chk("mid_addr1", app_addr, 29'h308);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_state", state, 0);
        chk("mid_rst_en", app_en, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_wren", app_wdf_wren, 0);
        app_rdy = 1'b0; app_wdf_rdy = 1'b0; app_rd_data_valid = 1'b1;
        #1;
        chk("stray_rbeat", rbeat, 0);
        @(negedge clk);
        #1;
        chk("stray_cnt", burst_cnt, 0);
        app_rd_data_valid = 1'b0;

        // Read with the command port stalled.
        start(1'b0, 29'h400, 8'd2);
        for (int i = 0; i < TO + 6; i++) begin
            if (i > 0) @(negedge clk);
            app_rdy = 1'b0;
            #1;
`ifdef MPMC11_SEQ_TIMEOUT_EN
            chk("stall_state", state, (i < TO) ? 2 : (i == TO) ? 4 : 0);
            chk("stall_done", done, (i == TO));
            if (i == TO) chk("stall_err", err, 1);
`else
            chk("stall_state", state, 2);
            chk("stall_err", err, 0);
            chk("stall_done", done, 0);
`endif
            chk("stall_en", app_en, 0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("final_idle", state, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
